// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-shift controller.
// Contents: controller FSM state enum, PHASESEL output encodings, and the
// per-output phase-position wrap lookup (8 positions per VCO-to-output divider).
package pll_phase_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StSettle,
        StDone,
        StAbort
    } state_e;

    // PHASESEL encodings; also the index of each output's slot in pos_all.
    localparam logic [1:0] SEL_OS  = 2'b00;
    localparam logic [1:0] SEL_OS2 = 2'b01;
    localparam logic [1:0] SEL_OS3 = 2'b10;
    localparam logic [1:0] SEL_OP  = 2'b11;

    // Phase positions per output period (8 * output divider).
    localparam int unsigned WRAP_OP  = 40;
    localparam int unsigned WRAP_OS  = 8;
    localparam int unsigned WRAP_OS2 = 200;
    localparam int unsigned WRAP_OS3 = 80;

    function automatic int unsigned wrap_of(input logic [1:0] sel);
        int unsigned w;
        case (sel)
            SEL_OS:  w = WRAP_OS;
            SEL_OS2: w = WRAP_OS2;
            SEL_OS3: w = WRAP_OS3;
            default: w = WRAP_OP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock.sv
// PLL lock qualifier.
// Synchronises the asynchronous PLL LOCK into the controller clock with two
// flops, then requires LOCK_FILTER consecutive high samples before reporting
// a stable lock. A single low synchronised sample drops the stable flag on the
// following cycle.
// Ports:
//   clk_i            controller clock
//   rst_ni           asynchronous active-low reset
//   pll_locked_i     raw PLL LOCK (asynchronous)
//   locked_stable_o  filtered lock
module pll_lock_filter #(
    parameter int unsigned LOCK_FILTER = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    output logic locked_stable_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic phase-shift sequencer.
// Accepts step requests over valid/ready, drives PHASESEL/PHASEDIR/PHASESTEP,
// tracks the phase position of every PLL output and aborts on lock loss.
// Ports:
//   clk_i, rst_ni              reference clock, async active-low reset
//   req_valid_i/req_ready_o    request handshake
//   req_sel_i/req_dir_i        output select (00 OS,01 OS2,10 OS3,11 OP), 0=delay 1=advance
//   req_steps_i                step count, 0 = no-op
//   done_o/busy_o/err_o        completion pulse, in-progress, sticky lock-loss abort
//   pos_all_o                  four positions, CLKOS in the low slice, CLKOP on top
//   pll_locked_i               raw PLL LOCK
//   locked_stable_o            filtered lock
//   pll_phase*_o               to the EHXPLLL dynamic phase pins
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int unsigned POS_W             = 8,
    parameter int unsigned STEP_PULSE_CYCLES = 4,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned SETTLE_CYCLES     = 16,
    parameter int unsigned LOCK_FILTER       = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_sel_i,
    input  logic               req_dir_i,
    input  logic [POS_W-1:0]   req_steps_i,
    output logic               done_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [4*POS_W-1:0] pos_all_o,
    input  logic               pll_locked_i,
    output logic               locked_stable_o,
    output logic [1:0]         pll_phasesel_o,
    output logic               pll_phasedir_o,
    output logic               pll_phasestep_o,
    output logic               pll_phaseloadreg_o
);

    localparam int unsigned CNT_MAX0 =
        (STEP_PULSE_CYCLES > SETUP_CYCLES) ? STEP_PULSE_CYCLES : SETUP_CYCLES;
    localparam int unsigned CNT_MAX  = (SETTLE_CYCLES > CNT_MAX0) ? SETTLE_CYCLES : CNT_MAX0;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(STEP_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic [POS_W-1:0]   rem_q, rem_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   pos_q [4];
    logic [POS_W-1:0]   pos_d [4];

    logic               locked;
    logic               accept;
    logic               pulse_end;
    logic [POS_W-1:0]   wrap_last;
    logic [POS_W-1:0]   pos_cur;
    logic [POS_W-1:0]   pos_step;

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pll_locked_i    (pll_locked_i),
        .locked_stable_o (locked)
    );

    assign accept    = req_valid_i & req_ready_o;
    // Last pulse cycle: PHASESTEP rises on this edge, which is when the PLL moves.
    assign pulse_end = (state_q == StPulse) && (cnt_q == PULSE_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (req_steps_i == '0) ? StDone : StSetup;
                end
            end
            StSetup: begin
                if (!locked) begin
                    state_d = StAbort;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = StPulse;
                end
            end
            // Lock loss is deliberately ignored here so a started pulse always completes.
            StPulse: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!locked) begin
                    state_d = StAbort;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = (rem_q == '0) ? StDone : StPulse;
                end
            end
            StDone, StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_o     = (state_q == StIdle) && locked && !done_q;
        busy_o          = (state_q != StIdle);
        pll_phasestep_o = (state_q != StPulse);
    end

    // Next position of the selected output, wrapping at its period.
    always_comb begin
        wrap_last = POS_W'(wrap_of(sel_q) - 1);
        pos_cur   = pos_q[sel_q];
        if (!dir_q) begin
            pos_step = (pos_cur == wrap_last) ? '0 : pos_cur + POS_W'(1);
        end else begin
            pos_step = (pos_cur == '0) ? wrap_last : pos_cur - POS_W'(1);
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        sel_d  = sel_q;
        dir_d  = dir_q;
        rem_d  = rem_q;
        err_d  = err_q;
        done_d = (state_q == StDone) || (state_q == StAbort);
        pos_d  = pos_q;
        if (accept) begin
            sel_d = req_sel_i;
            dir_d = req_dir_i;
            rem_d = req_steps_i;
            err_d = 1'b0;
        end
        if (pulse_end) begin
            pos_d[sel_q] = pos_step;
            rem_d        = rem_q - POS_W'(1);
        end
        if (state_q == StAbort) begin
            err_d = 1'b1;
            rem_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sel_q  <= 2'b00;
            dir_q  <= 1'b0;
            rem_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            dir_q  <= dir_d;
            rem_q  <= rem_d;
            err_q  <= err_d;
            done_q <= done_d;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    assign done_o             = done_q;
    assign err_o              = err_q;
    assign pos_all_o          = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
    assign locked_stable_o    = locked;
    assign pll_phasesel_o     = sel_q;
    assign pll_phasedir_o     = dir_q;
    assign pll_phaseloadreg_o = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
module tb_pll_phase_ctrl;

    localparam int unsigned POS_W = 8;
    localparam int LOCK_CYC = 1024 + 2;

    logic             clk;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_sel_i;
    logic             req_dir_i;
    logic [POS_W-1:0] req_steps_i;
    logic             done_o;
    logic             busy_o;
    logic             err_o;
    logic [31:0]      pos_all_o;
    logic             pll_locked_i;
    logic             locked_stable_o;
    logic [1:0]       pll_phasesel_o;
    logic             pll_phasedir_o;
    logic             pll_phasestep_o;
    logic             pll_phaseloadreg_o;

    int checks = 0;
    int failures = 0;

    pll_phase_ctrl dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_sel_i          (req_sel_i),
        .req_dir_i          (req_dir_i),
        .req_steps_i        (req_steps_i),
        .done_o             (done_o),
        .busy_o             (busy_o),
        .err_o              (err_o),
        .pos_all_o          (pos_all_o),
        .pll_locked_i       (pll_locked_i),
        .locked_stable_o    (locked_stable_o),
        .pll_phasesel_o     (pll_phasesel_o),
        .pll_phasedir_o     (pll_phasedir_o),
        .pll_phasestep_o    (pll_phasestep_o),
        .pll_phaseloadreg_o (pll_phaseloadreg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        dir;
        logic [7:0]  steps;
        logic [31:0] exp_pos;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!locked_stable_o && n < 1200);
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!req_ready_o && g < 3000) begin
            @(posedge clk);
            @(negedge clk);
            g++;
        end
        chk("ready_before_req", 32'(req_ready_o), 32'd1);
    endtask

    // Issue one request from a negedge with ready high; returns at the negedge where done is seen.
    task automatic do_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                          input int drop_at, output int lat, output int lows, output int falls,
                          output int sel_bad, output logic busy1, output logic err1);
        logic prev_ps;
        wait_ready();
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        req_dir_i   = dir;
        req_steps_i = steps;
        lat = 0; lows = 0; falls = 0; sel_bad = 0;
        prev_ps = 1'b1; busy1 = 1'b0; err1 = 1'b1;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid_i = 1'b0;
                busy1 = busy_o;
                err1  = err_o;
            end
            if (drop_at != 0 && lat == drop_at) pll_locked_i = 1'b0;
            if (pll_phasesel_o != sel || pll_phasedir_o != dir) sel_bad++;
            if (!pll_phasestep_o) begin
                lows++;
                if (prev_ps) falls++;
            end
            prev_ps = pll_phasestep_o;
        end while (!done_o && lat < 300);
    endtask

    initial begin
        int n, lat, lows, falls, sel_bad;
        logic busy1, err1;

        vecs[0] = '{2'b11, 1'b0, 8'd3, 32'h0300_0000};
        vecs[1] = '{2'b01, 1'b1, 8'd1, 32'h0300_C700};
        vecs[2] = '{2'b10, 1'b0, 8'd0, 32'h0300_C700};
        vecs[3] = '{2'b00, 1'b1, 8'd2, 32'h0300_C706};
        vecs[4] = '{2'b10, 1'b1, 8'd1, 32'h034F_C706};
        vecs[5] = '{2'b01, 1'b0, 8'd1, 32'h034F_0006};

        rst_ni = 1'b0;
        pll_locked_i = 1'b1;
        req_valid_i = 1'b0;
        req_sel_i = 2'b00;
        req_dir_i = 1'b0;
        req_steps_i = '0;

        #23;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_pos", pos_all_o, 32'd0);
        chk("rst_sel", 32'(pll_phasesel_o), 32'd0);
        chk("rst_dir", 32'(pll_phasedir_o), 32'd0);
        chk("rst_step", 32'(pll_phasestep_o), 32'd1);
        chk("rst_loadreg", 32'(pll_phaseloadreg_o), 32'd1);
        chk("rst_lock", 32'(locked_stable_o), 32'd0);

        @(negedge clk);
        rst_ni = 1'b1;
        wait_lock(n);
        chk("lock_latency", 32'(n), 32'(LOCK_CYC));
        chk("ready_with_lock", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].sel, vecs[i].dir, vecs[i].steps, 0, lat, lows, falls, sel_bad,
                   busy1, err1);
            chk($sformatf("v%0d_latency", i), 32'(lat),
                (vecs[i].steps == 0) ? 32'd2 : 32'(4 + 20 * int'(vecs[i].steps)));
            chk($sformatf("v%0d_pos", i), pos_all_o, vecs[i].exp_pos);
            chk($sformatf("v%0d_low_cycles", i), 32'(lows), 32'(4 * int'(vecs[i].steps)));
            chk($sformatf("v%0d_pulses", i), 32'(falls), 32'(vecs[i].steps));
            chk($sformatf("v%0d_sel_dir_stable", i), 32'(sel_bad), 32'd0);
            chk($sformatf("v%0d_busy_after_accept", i), 32'(busy1), 32'd1);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_done_single", i), 32'(done_o), 32'd0);
            chk($sformatf("v%0d_sel_hold", i), 32'(pll_phasesel_o), 32'(vecs[i].sel));
        end

        // Reset asserted during a PULSE.
        wait_ready();
        req_valid_i = 1'b1;
        req_sel_i = 2'b11;
        req_dir_i = 1'b0;
        req_steps_i = 8'd2;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            req_valid_i = 1'b0;
            n++;
        end while (pll_phasestep_o && n < 50);
        chk("midpulse_reached", 32'(pll_phasestep_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("midpulse_rst_step", 32'(pll_phasestep_o), 32'd1);
        chk("midpulse_rst_busy", 32'(busy_o), 32'd0);
        chk("midpulse_rst_pos", pos_all_o, 32'd0);
        chk("midpulse_rst_sel", 32'(pll_phasesel_o), 32'd0);
        chk("midpulse_rst_lock", 32'(locked_stable_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        wait_lock(n);
        chk("relock_after_rst", 32'(n), 32'(LOCK_CYC));

        // Lock loss during the 3rd SETTLE of a 5-step request.
        do_req(2'b00, 1'b0, 8'd5, 48, lat, lows, falls, sel_bad, busy1, err1);
        chk("abort_done_seen", 32'(done_o), 32'd1);
        chk("abort_err", 32'(err_o), 32'd1);
        chk("abort_pos", pos_all_o, 32'h0000_0003);
        chk("abort_pulses", 32'(falls), 32'd3);
        chk("abort_step_high", 32'(pll_phasestep_o), 32'd1);
        chk("abort_ready", 32'(req_ready_o), 32'd0);
        chk("abort_in_settle", 32'((lat > 48 && lat <= 64) ? 1 : 0), 32'd1);
        repeat (5) @(negedge clk);
        chk("abort_ready_unlocked", 32'(req_ready_o), 32'd0);
        chk("abort_err_sticky", 32'(err_o), 32'd1);
        pll_locked_i = 1'b1;
        wait_lock(n);
        chk("relock_after_abort", 32'(n), 32'(LOCK_CYC));
        chk("ready_after_relock", 32'(req_ready_o), 32'd1);

        // New acceptance clears err.
        do_req(2'b10, 1'b0, 8'd0, 0, lat, lows, falls, sel_bad, busy1, err1);
        chk("err_cleared_on_accept", 32'(err1), 32'd0);
        chk("noop_latency", 32'(lat), 32'd2);
        chk("noop_pos", pos_all_o, 32'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
